// File: rtl/pi_loop_filter_sat.sv
// Two-stage PI loop filter: power-of-two gains, symmetric integrator/output
// saturation with anti-windup, freeze/clear controls and an error-magnitude lock detector.
module pi_loop_filter_sat #(
    parameter int WERR      = 18,
    parameter int WOUT      = 18,
    parameter int ACC_WIDTH = 24,
    parameter int SH_W      = 5,
    parameter int LOCK_THR  = 256,
    parameter int LOCK_CNT  = 16,
    parameter int CNT_W     = $clog2(LOCK_CNT + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic signed [WERR-1:0] e_in_i,
    input  logic                   e_valid_i,
    input  logic [SH_W-1:0]        kp_shift_i,
    input  logic [SH_W-1:0]        ki_shift_i,
    input  logic                   freeze_i,
    input  logic                   clear_i,
    output logic signed [WOUT-1:0] ctrl_o,
    output logic                   ctrl_val_o,
    output logic                   sat_o,
    output logic                   lock_o
);

    localparam int XW = ACC_WIDTH + 1;
    localparam logic signed [XW-1:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] OUT_MAX = {{(XW-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
    localparam logic [WERR:0]        LOCK_THR_C = (WERR+1)'(LOCK_THR);
    localparam logic [CNT_W-1:0]     LOCK_CNT_C = CNT_W'(LOCK_CNT);

    // Magnitude is one bit wider so the most negative code does not wrap.
    function automatic logic [WERR:0] abs_e(input logic signed [WERR-1:0] e);
        logic signed [WERR:0] ext;
        ext = {e[WERR-1], e};
        return ext[WERR] ? $unsigned(-ext) : $unsigned(ext);
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sym_shift(
        input logic signed [WERR-1:0] e,
        input logic [SH_W-1:0]        s
    );
        logic [WERR:0]                 mag;
        logic [WERR:0]                 shr;
        logic signed [ACC_WIDTH-1:0]   wide;
        mag  = abs_e(e);
        shr  = (32'(s) >= WERR) ? '0 : (mag >> s);
        wide = signed'(ACC_WIDTH'(shr));
        if (e[WERR-1]) begin
            wide = -wide;
        end
        return wide;
    endfunction

    // Stage 1 state
    logic                          r_v1;
    logic signed [ACC_WIDTH-1:0]   r_prop;
    logic signed [ACC_WIDTH-1:0]   r_integ;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_lock;

    // Stage 2 state
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic signed [WOUT-1:0]        r_ctrl;
    logic                          r_val;
    logic                          r_sat;

    logic signed [ACC_WIDTH-1:0]   w_prop;
    logic signed [ACC_WIDTH-1:0]   w_integ;
    logic                          w_in_lock;
    logic [CNT_W-1:0]              w_cnt_n;

    logic signed [ACC_WIDTH-1:0]   w_inc;
    logic signed [XW-1:0]          w_sum;
    logic signed [ACC_WIDTH-1:0]   w_acc_c;
    logic                          w_acc_hit;
    logic signed [ACC_WIDTH-1:0]   w_acc_n;
    logic                          w_isat;
    logic signed [XW-1:0]          w_y;
    logic signed [WOUT-1:0]        w_ctrl;
    logic                          w_osat;

    assign w_prop    = sym_shift(e_in_i, kp_shift_i);
    assign w_integ   = sym_shift(e_in_i, ki_shift_i);
    assign w_in_lock = (abs_e(e_in_i) <= LOCK_THR_C);

    always_comb begin
        w_cnt_n = r_cnt;
        if (clear_i) begin
            w_cnt_n = '0;
        end else if (e_valid_i) begin
            if (!w_in_lock) begin
                w_cnt_n = '0;
            end else if (r_cnt != LOCK_CNT_C) begin
                w_cnt_n = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1    <= 1'b0;
            r_prop  <= '0;
            r_integ <= '0;
            r_cnt   <= '0;
            r_lock  <= 1'b0;
        end else begin
            r_v1   <= e_valid_i;
            r_cnt  <= w_cnt_n;
            r_lock <= (w_cnt_n == LOCK_CNT_C);
            if (e_valid_i) begin
                r_prop  <= w_prop;
                r_integ <= w_integ;
            end
        end
    end

    // Landing exactly on a rail counts as a saturation hit.
    always_comb begin
        w_inc     = freeze_i ? '0 : r_integ;
        w_sum     = {r_acc[ACC_WIDTH-1], r_acc} + {w_inc[ACC_WIDTH-1], w_inc};
        w_acc_c   = w_sum[ACC_WIDTH-1:0];
        w_acc_hit = 1'b0;
        if (w_sum >= ACC_MAX) begin
            w_acc_c   = ACC_MAX[ACC_WIDTH-1:0];
            w_acc_hit = 1'b1;
        end else if (w_sum <= -ACC_MAX) begin
            w_acc_c   = -ACC_MAX[ACC_WIDTH-1:0];
            w_acc_hit = 1'b1;
        end
        w_acc_n = clear_i ? '0 : w_acc_c;
        w_isat  = w_acc_hit & ~clear_i;

        w_y    = {r_prop[ACC_WIDTH-1], r_prop} + {w_acc_n[ACC_WIDTH-1], w_acc_n};
        w_ctrl = w_y[WOUT-1:0];
        w_osat = 1'b0;
        if (w_y >= OUT_MAX) begin
            w_ctrl = OUT_MAX[WOUT-1:0];
            w_osat = 1'b1;
        end else if (w_y <= -OUT_MAX) begin
            w_ctrl = -OUT_MAX[WOUT-1:0];
            w_osat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc  <= '0;
            r_ctrl <= '0;
            r_val  <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            r_val <= r_v1;
            r_sat <= r_v1 & (w_isat | w_osat);
            if (clear_i) begin
                r_acc <= '0;
            end else if (r_v1) begin
                r_acc <= w_acc_n;
            end
            if (r_v1) begin
                r_ctrl <= w_ctrl;
            end
        end
    end

    assign ctrl_o     = r_ctrl;
    assign ctrl_val_o = r_val;
    assign sat_o      = r_sat;
    assign lock_o     = r_lock;

endmodule

// File: tb/tb_pi_loop_filter_sat.sv
// Bench for pi_loop_filter_sat: table vectors, directed corner sequences and
// randomized traffic against an arithmetic reference model.
module tb_pi_loop_filter_sat;

    localparam int WERR = 18;
    localparam int WOUT = 18;
    localparam int ACC_WIDTH = 24;
    localparam int SH_W = 5;
    localparam longint AMAX = (64'sd1 <<< (ACC_WIDTH - 1)) - 1;
    localparam longint OMAX = (64'sd1 <<< (WOUT - 1)) - 1;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic signed [WERR-1:0] e_in_i = '0;
    logic                   e_valid_i = 1'b0;
    logic [SH_W-1:0]        kp_shift_i = '0;
    logic [SH_W-1:0]        ki_shift_i = '0;
    logic                   freeze_i = 1'b0;
    logic                   clear_i = 1'b0;
    logic signed [WOUT-1:0] ctrl_o;
    logic                   ctrl_val_o;
    logic                   sat_o;
    logic                   lock_o;

    pi_loop_filter_sat #(
        .WERR(WERR), .WOUT(WOUT), .ACC_WIDTH(ACC_WIDTH), .SH_W(SH_W),
        .LOCK_THR(256), .LOCK_CNT(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .e_in_i(e_in_i), .e_valid_i(e_valid_i),
        .kp_shift_i(kp_shift_i), .ki_shift_i(ki_shift_i), .freeze_i(freeze_i),
        .clear_i(clear_i), .ctrl_o(ctrl_o), .ctrl_val_o(ctrl_val_o),
        .sat_o(sat_o), .lock_o(lock_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { longint prop; longint integ; } pend_t;
    pend_t  pend[$];
    longint m_acc, m_ctrl;
    bit     m_val, m_sat, m_lock;
    int     m_cnt;

    typedef struct { int e; int kp; int ki; int exp_ctrl; bit exp_sat; } vec_t;
    vec_t vt[12];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint shf(input longint e, input int s);
        longint m;
        if (s >= WERR) return 0;
        m = labs(e) / (64'sd1 <<< s);
        return (e < 0) ? -m : m;
    endfunction

    function automatic longint clampv(input longint v, input longint lim);
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_acc = 0; m_ctrl = 0; m_val = 0; m_sat = 0; m_lock = 0; m_cnt = 0;
    endtask

    // One clock: capture inputs, advance the model, compare all outputs.
    task automatic step();
        longint e  = e_in_i;
        bit     ev = e_valid_i;
        bit     fr = freeze_i;
        bit     cl = clear_i;
        int     kp = kp_shift_i;
        int     ki = ki_shift_i;
        pend_t  p;
        longint raw, accn, y;
        bit     isat;
        @(posedge clk);
        #1;
        if (pend.size() > 0) begin
            p    = pend.pop_front();
            raw  = m_acc + (fr ? 0 : p.integ);
            accn = cl ? 0 : clampv(raw, AMAX);
            isat = !cl && (labs(raw) >= AMAX);
            y    = p.prop + accn;
            m_ctrl = clampv(y, OMAX);
            m_sat  = isat || (labs(y) >= OMAX);
            m_acc  = accn;
            m_val  = 1;
        end else begin
            m_val = 0;
            m_sat = 0;
            if (cl) m_acc = 0;
        end
        if (ev) pend.push_back('{shf(e, kp), shf(e, ki)});
        if (cl) m_cnt = 0;
        else if (ev) m_cnt = (labs(e) <= 256) ? ((m_cnt < 16) ? m_cnt + 1 : 16) : 0;
        m_lock = (m_cnt == 16);
        chk("ctrl_val_o", ctrl_val_o, m_val);
        chk("ctrl_o", $signed(ctrl_o), m_ctrl);
        chk("sat_o", sat_o, m_sat);
        chk("lock_o", lock_o, m_lock);
    endtask

    task automatic strobe(input int e);
        e_in_i = WERR'(e);
        e_valid_i = 1'b1;
        step();
        e_valid_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    initial begin
        vt[0]  = '{1000,    7, 11,  7,      1'b0};
        vt[1]  = '{-1000,   7, 11, -7,      1'b0};
        vt[2]  = '{4096,    7, 11,  34,     1'b0};
        vt[3]  = '{-131072, 0, 31, -131071, 1'b1};
        vt[4]  = '{-131072, 0, 0,  -131071, 1'b1};
        vt[5]  = '{131071,  0, 17,  131071, 1'b1};
        vt[6]  = '{-1,      1, 0,  -1,      1'b0};
        vt[7]  = '{-3,      1, 1,  -2,      1'b0};
        vt[8]  = '{100,     18, 20, 0,      1'b0};
        vt[9]  = '{131071,  17, 16, 1,      1'b0};
        vt[10] = '{-131072, 17, 17, -2,     1'b0};
        vt[11] = '{5,       0, 2,   6,      1'b0};

        model_reset();
        #12;
        chk("reset_ctrl", $signed(ctrl_o), 0);
        chk("reset_val", ctrl_val_o, 0);
        chk("reset_sat", sat_o, 0);
        chk("reset_lock", lock_o, 0);
        reset_n = 1'b1;

        // Single samples, latency 2
        kp_shift_i = 5'd7; ki_shift_i = 5'd11;
        strobe(1000);
        chk("lat_n1_val", ctrl_val_o, 0);
        step();
        chk("lat_n2_val", ctrl_val_o, 1);
        chk("tp1_pos", $signed(ctrl_o), 7);
        strobe(-1000); step();
        chk("tp1_neg", $signed(ctrl_o), -7);
        strobe(0); step();
        chk("tp1_acc0", $signed(ctrl_o), 0);

        // Back-to-back
        e_in_i = 18'sd4096; e_valid_i = 1'b1;
        step(); step();
        chk("b2b_1", $signed(ctrl_o), 34);
        step();
        chk("b2b_2", $signed(ctrl_o), 36);
        e_valid_i = 1'b0; step();
        chk("b2b_3", $signed(ctrl_o), 38);
        chk("b2b_sat", sat_o, 0);
        strobe(0); step();
        chk("b2b_acc6", $signed(ctrl_o), 6);

        // Table vectors, each from a cleared integrator
        for (int i = 0; i < 12; i++) begin
            kp_shift_i = SH_W'(vt[i].kp);
            ki_shift_i = SH_W'(vt[i].ki);
            do_clear();
            strobe(vt[i].e);
            step();
            chk($sformatf("vec%0d_val", i), ctrl_val_o, 1);
            chk($sformatf("vec%0d_ctrl", i), $signed(ctrl_o), vt[i].exp_ctrl);
            chk($sformatf("vec%0d_sat", i), sat_o, vt[i].exp_sat);
        end

        // Integrator and output saturation, then recovery
        do_clear();
        kp_shift_i = 5'd31; ki_shift_i = 5'd0;
        e_in_i = 18'sd131071; e_valid_i = 1'b1;
        for (int i = 0; i < 65; i++) begin
            step();
            if (i >= 1) begin
                chk("satup_ctrl", $signed(ctrl_o), 131071);
                chk("satup_sat", sat_o, 1);
            end
        end
        e_in_i = -18'sd131071;
        for (int j = 0; j < 64; j++) begin
            step();
            if (j < 2) begin
                chk("satdn_ctrl", $signed(ctrl_o), 131071);
                chk("satdn_sat", sat_o, 1);
            end
        end
        e_valid_i = 1'b0; step();
        chk("recover_ctrl", $signed(ctrl_o), 63);
        chk("recover_sat", sat_o, 0);

        // Freeze, then clear coincident with stage 2
        do_clear();
        kp_shift_i = 5'd7; ki_shift_i = 5'd11;
        strobe(4096); step();
        chk("frz_pre", $signed(ctrl_o), 34);
        freeze_i = 1'b1;
        e_in_i = 18'sd4096; e_valid_i = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) e_valid_i = 1'b0;
            step();
            chk("frz_hold", $signed(ctrl_o), 34);
        end
        freeze_i = 1'b0;
        e_valid_i = 1'b1; step(); step();
        chk("frz_rel1", $signed(ctrl_o), 36);
        e_valid_i = 1'b0; step();
        chk("frz_rel2", $signed(ctrl_o), 38);
        strobe(4096);
        clear_i = 1'b1; step(); clear_i = 1'b0;
        chk("clr_s2_ctrl", $signed(ctrl_o), 32);
        strobe(4096); step();
        chk("clr_s2_acc0", $signed(ctrl_o), 34);

        // Lock detector
        do_clear();
        e_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e_in_i = (i % 2 == 0) ? 18'sd200 : -18'sd200;
            step();
            chk("lock_rise", lock_o, (i == 15) ? 1 : 0);
        end
        e_in_i = 18'sd300; step();
        chk("lock_drop", lock_o, 0);
        e_in_i = -18'sd256;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("lock_relock", lock_o, (i == 15) ? 1 : 0);
        end
        e_valid_i = 1'b0;
        do_clear();
        chk("lock_clear", lock_o, 0);

        // Async reset with a sample in flight
        e_in_i = 18'sd4096; e_valid_i = 1'b1;
        step(); step();
        chk("prerst_val", ctrl_val_o, 1);
        e_valid_i = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_ctrl", $signed(ctrl_o), 0);
        chk("rst_val", ctrl_val_o, 0);
        chk("rst_sat", sat_o, 0);
        chk("rst_lock", lock_o, 0);
        model_reset();
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postrst_noval", ctrl_val_o, 0);
        end
        strobe(4096); step();
        chk("postrst_ctrl", $signed(ctrl_o), 34);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 3))
                0: e_in_i = WERR'(int'($urandom_range(0, 600)) - 300);
                1: e_in_i = WERR'($urandom);
                2: case ($urandom_range(0, 2))
                       0: e_in_i = -18'sd131072;
                       1: e_in_i = 18'sd131071;
                       default: e_in_i = -18'sd131071;
                   endcase
                default: e_in_i = WERR'(int'($urandom_range(0, 8191)) - 4096);
            endcase
            e_valid_i  = ($urandom_range(0, 9) < 7);
            freeze_i   = ($urandom_range(0, 19) < 3);
            clear_i    = ($urandom_range(0, 39) == 0);
            kp_shift_i = ($urandom_range(0, 1) == 0) ? SH_W'($urandom_range(0, 12))
                                                     : SH_W'($urandom_range(0, 31));
            ki_shift_i = ($urandom_range(0, 1) == 0) ? SH_W'($urandom_range(0, 4))
                                                     : SH_W'($urandom_range(0, 31));
            step();
        end
        e_valid_i = 1'b0; freeze_i = 1'b0; clear_i = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pi_loop_filter_sat.md
Name: pi_loop_filter_sat

Overview:
Second-generation PI loop filter for the MSK receiver timing and carrier loops. It takes the TED/PED error strobe and produces a correction word for the phase accumulator.
- Proportional and integral gains are power-of-two shifts selectable at run time.
- Integrator and output saturate symmetrically; freeze and clear controls are provided.
- A lock detector watches error magnitude.
- Two-stage pipeline; back-to-back valid samples are supported.

Parameters:
WERR, 18, width of e_in_i
WOUT, 18, width of ctrl_o
ACC_WIDTH, 24, integrator width; must be >= WERR and >= WOUT
SH_W, 5, width of the shift-select inputs
LOCK_THR, 256, |e| at or below this value counts as "in lock"
LOCK_CNT, 16, consecutive in-lock samples required to assert lock_o
CNT_W, $clog2(LOCK_CNT+1), width of the lock counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
e_in_i  in  WERR  signed error sample
e_valid_i  in  1  1-cycle strobe qualifying e_in_i
kp_shift_i  in  SH_W  Kp = 2^-kp_shift_i
ki_shift_i  in  SH_W  Ki = 2^-ki_shift_i
freeze_i  in  1  hold the integrator (no accumulation)
clear_i  in  1  synchronous clear of integrator and lock state
ctrl_o  out  WOUT  signed correction, saturated
ctrl_val_o  out  1  1-cycle strobe qualifying ctrl_o
sat_o  out  1  valid with ctrl_val_o; this sample hit integrator or output saturation
lock_o  out  1  lock indication, level

Behaviour:
- Reset (async assert, sync release): ctrl_o=0, ctrl_val_o=0, sat_o=0, lock_o=0, acc=0, lock counter=0, all pipeline valids 0.

Shift rule (symmetric truncation toward zero):
- term = sign(e) * (|e| >> s).
- Any |e| < 2^s gives 0.
- s=0 passes e through unchanged.
- s >= WERR gives 0.
- |e| of the most negative code is computed in WERR+1 bits; no wrap.

Stage 1, on the cycle e_valid_i=1:
- Register prop = shift(e, kp_shift_i) and integ = shift(e, ki_shift_i), sign-extended to ACC_WIDTH.
- Shift inputs are sampled only here; a shift change affects the next sample only.
- Register v1=1; otherwise v1=0.
- Update the lock counter:
  - |e| <= LOCK_THR: cnt = min(cnt+1, LOCK_CNT).
  - otherwise: cnt=0 and lock_o drops to 0 the next cycle.
  - lock_o=1 once cnt==LOCK_CNT.

Stage 2, on the cycle v1=1:
- Integrator step:
  - inc = freeze_i ? 0 : integ.
  - sum = acc + inc, computed in ACC_WIDTH+1 bits.
  - acc_n = sum clamped to ±(2^(ACC_WIDTH-1)-1).
- Output:
  - y = prop + acc_n, computed in ACC_WIDTH+1 bits.
  - ctrl_o = y clamped to ±(2^(WOUT-1)-1).
- Write acc <= acc_n. Set ctrl_val_o=1 and sat_o = (either clamp active).
- When v1=0: ctrl_val_o=0, sat_o=0, ctrl_o holds its value, acc holds.
- The output uses the updated integrator (same-sample feedthrough).

Latency and throughput:
- e_valid_i at cycle N gives ctrl_val_o at cycle N+2.
- One result per input strobe; continuous strobing is legal.

Clamping:
- Both clamps are symmetric; the most negative code is never produced.
- The integrator recovers immediately when the error reverses sign (anti-windup by clamping).

clear_i, sampled every cycle:
- acc <= 0, lock counter <= 0, lock_o <= 0.
- If clear_i coincides with v1=1, clear wins for acc (acc <= 0) and ctrl_o = clamp(prop + 0).
- If clear_i coincides with a stage-1 valid, lock state is cleared and that sample is not counted.
- The pipeline is not flushed: an in-flight sample still emits.

freeze_i:
- Sampled at stage 2; affects the integrator only.
- The proportional path and the lock detector remain live.

Reset mid-operation: in-flight samples are discarded; no ctrl_val_o is emitted for them.

Test Plan:
- kp=7, ki=11, single e=1000 -> ctrl_o=7 with ctrl_val_o exactly 2 cycles later; then e=-1000 -> ctrl_o=-7; acc stays 0.
- kp=7, ki=11, three back-to-back e=4096 -> ctrl_o=34, 36, 38 on consecutive cycles; acc ends at 6; sat_o=0.
- ki=0, kp=31, continuous e=131071 -> acc reaches 8388607 on the 65th sample with sat_o=1 from that sample on; ctrl_o=131071 (output clamp active from the 1st sample, sat_o=1); then e=-131071 -> acc=8257536 on the next result.
- freeze_i=1 with e=4096 repeated (kp=7, ki=11) -> ctrl_o=32+acc_prev constant; release freeze -> accumulation resumes +2 per sample; clear_i pulse coincident with a stage-2 sample -> that ctrl_o=32, acc=0.
- Lock: 16 samples of e=±200 -> lock_o rises after the 16th; one e=300 -> lock_o=0 next cycle; 15 more in-lock samples -> still 0; 16th -> 1; clear_i -> 0.
- Async reset asserted mid-stream with v1=1 -> all outputs 0 immediately; no ctrl_val_o after release until a new e_valid_i plus 2 cycles.
